// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: opcodes, control steps, the strobe bundle
// and the opcode-to-sequence-class mapping used by the decoder.
package minisrc_pkg;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                           OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                           OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8,
                           OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11,
                           OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14,
                           OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17,
                           OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20,
                           OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23,
                           OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26,
                           OP_HALT = 5'd27;

    localparam int WAIT_W = 3;

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_e;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_e;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, BAout;
        logic PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
        logic RYin, RZin, RZHIout, RZLOout, Cout, HIin, LOin, HIout, LOout;
        logic InPortOut, OutPortIn, R15in, con_in;
    } strobes_t;

    function automatic op_class_e op_class(input logic [4:0] op);
        case (op)
            OP_LD:                              return C_LD;
            OP_LDI:                             return C_LDI;
            OP_ST:                              return C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:    return C_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:           return C_IMM;
            OP_MUL, OP_DIV:                     return C_MULDIV;
            OP_NEG, OP_NOT:                     return C_UNARY;
            OP_BR:                              return C_BR;
            OP_JR:                              return C_JR;
            OP_JAL:                             return C_JAL;
            OP_IN:                              return C_IN;
            OP_OUT:                             return C_OUT;
            OP_MFHI:                            return C_MFHI;
            OP_MFLO:                            return C_MFLO;
            OP_HALT:                            return C_HALT;
            default:                            return C_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> DataPath bundle: IR and CON FF in, run/strobes/ALU select out.
interface control_unit_if;
    import minisrc_pkg::*;

    logic [31:0] ir;
    logic        con_ff;
    logic        run;
    strobes_t    strobes;
    logic [31:0] ops;

    modport master (input ir, con_ff, output run, strobes, ops);
    modport slave  (output ir, con_ff, input run, strobes, ops);
endinterface

// File: rtl/cu_decode.sv
// Combinational step decoder: (opcode, step, con_ff, wait count) -> strobes,
// ALU select, end-of-instruction, stay-in-step and halt-entry flags.
module cu_decode
    import minisrc_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  step_e             step,
    input  logic [4:0]        opcode,
    input  logic              con_ff,
    input  logic [WAIT_W-1:0] wait_cnt,
    output strobes_t          strobes,
    output logic [31:0]       ops,
    output logic              last_step,
    output logic              hold,
    output logic              halt_now
);
    op_class_e   cls;
    logic [31:0] op_sel;
    logic [31:0] add_sel;

    assign cls     = op_class(opcode);
    assign op_sel  = 32'd1 << opcode;
    assign add_sel = 32'd1 << OP_ADD;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        strobes   = '0;
        ops       = '0;
        last_step = 1'b0;
        hold      = 1'b0;
        halt_now  = 1'b0;
        case (step)
            T0: begin strobes.PCout = 1'b1; strobes.MARin = 1'b1; strobes.IncPC = 1'b1; end
            T1: begin
                strobes.Read = 1'b1;
                hold         = (wait_cnt != WAIT_W'(MEM_WAIT));
            end
            T2: begin
                strobes.Read = 1'b1; strobes.MDRin = 1'b1;
                strobes.MDRout = 1'b1; strobes.IRin = 1'b1;
            end
            T3: case (cls)
                C_ALU, C_IMM: begin strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.RYin = 1'b1; end
                C_LDI, C_LD, C_ST: begin strobes.grb = 1'b1; strobes.BAout = 1'b1; strobes.RYin = 1'b1; end
                C_MULDIV: begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.RYin = 1'b1; end
                C_UNARY: begin
                    strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.RZin = 1'b1; ops = op_sel;
                end
                C_BR:   begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.con_in = 1'b1; end
                C_JR:   begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.PCin = 1'b1; last_step = 1'b1; end
                C_JAL:  begin strobes.PCout = 1'b1; strobes.R15in = 1'b1; end
                C_IN:   begin strobes.InPortOut = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1; end
                C_OUT:  begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.OutPortIn = 1'b1; last_step = 1'b1; end
                C_MFHI: begin strobes.HIout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1; end
                C_MFLO: begin strobes.LOout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1; end
                C_HALT: halt_now = 1'b1;
                // ir only becomes valid in T3, so nop spends this one idle step before refetching.
                default: last_step = 1'b1;
            endcase
            T4: case (cls)
                C_ALU: begin strobes.grc = 1'b1; strobes.rout = 1'b1; strobes.RZin = 1'b1; ops = op_sel; end
                C_IMM: begin strobes.Cout = 1'b1; strobes.RZin = 1'b1; ops = op_sel; end
                C_LDI, C_LD, C_ST: begin strobes.Cout = 1'b1; strobes.RZin = 1'b1; ops = add_sel; end
                C_MULDIV: begin strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.RZin = 1'b1; ops = op_sel; end
                C_UNARY: begin strobes.RZLOout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1; end
                C_BR:    begin strobes.PCout = 1'b1; strobes.RYin = 1'b1; end
                C_JAL:   begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.PCin = 1'b1; last_step = 1'b1; end
                default: last_step = 1'b1;
            endcase
            T5: case (cls)
                C_ALU, C_IMM, C_LDI: begin
                    strobes.RZLOout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1;
                end
                C_LD, C_ST: begin strobes.RZLOout = 1'b1; strobes.MARin = 1'b1; end
                C_MULDIV:   begin strobes.RZLOout = 1'b1; strobes.LOin = 1'b1; end
                C_BR:       begin strobes.Cout = 1'b1; strobes.RZin = 1'b1; ops = add_sel; end
                default:    last_step = 1'b1;
            endcase
            T6: case (cls)
                C_LD: begin
                    strobes.Read  = 1'b1;
                    strobes.MDRin = (wait_cnt == WAIT_W'(MEM_WAIT + 1));
                    hold          = !strobes.MDRin;
                end
                C_ST:     begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.MDRin = 1'b1; end
                C_MULDIV: begin strobes.RZHIout = 1'b1; strobes.HIin = 1'b1; last_step = 1'b1; end
                C_BR:     begin strobes.RZLOout = 1'b1; strobes.PCin = con_ff; last_step = 1'b1; end
                default:  last_step = 1'b1;
            endcase
            T7: begin
                last_step = 1'b1;
                if (cls == C_LD) begin
                    strobes.MDRout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1;
                end else if (cls == C_ST) begin
                    strobes.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Mini SRC hardwired control unit: step register plus memory wait counter;
// strobes are decoded from the current step and forced low while clear is high.
module control_unit
    import minisrc_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master cu
);
    step_e             step_q, step_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    strobes_t          dec_strobes;
    logic [31:0]       dec_ops;
    logic              last_step, hold, halt_now;
    logic              unused_ir;

    cu_decode #(.MEM_WAIT(MEM_WAIT)) u_decode (
        .step      (step_q),
        .opcode    (cu.ir[31:27]),
        .con_ff    (cu.con_ff),
        .wait_cnt  (wait_q),
        .strobes   (dec_strobes),
        .ops       (dec_ops),
        .last_step (last_step),
        .hold      (hold),
        .halt_now  (halt_now)
    );

    always_comb begin
        step_d = step_q;
        wait_d = '0;
        if (step_q == HALT) begin
            step_d = HALT;
        end else if (halt_now) begin
            step_d = HALT;
        end else if (hold) begin
            wait_d = wait_q + 1'b1;
        end else if (last_step) begin
            step_d = T0;
        end else begin
            step_d = step_e'(4'(step_q) + 4'd1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            step_q <= T0;
            wait_q <= '0;
        end else begin
            step_q <= step_d;
            wait_q <= wait_d;
        end
    end

    assign cu.strobes = clear ? '0 : dec_strobes;
    assign cu.ops     = clear ? '0 : dec_ops;
    assign cu.run     = (step_q != HALT) && !halt_now;
    assign unused_ir  = ^cu.ir[26:0];
endmodule
